// File: rtl/issueq_regread_lanes.sv
// Issue-queue to register-read staging for NUM_LANES execution lanes.
// Each lane has a small skid FIFO with valid/ready handshaking. Inputs are
// accepted for the whole bundle or for none of it. A quiesce FSM drains every
// lane before it acknowledges a reconfiguration request.
module issueq_regread_lanes #(
   parameter int NUM_LANES  = 4,
   parameter int PKT_W      = 96,
   parameter int SKID_DEPTH = 2
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [NUM_LANES-1:0]                         laneActive_i,
   input  logic                                         flush_i,
   input  logic                                         cfgReq_i,
   output logic                                         cfgAck_o,
   input  logic [NUM_LANES-1:0]                         inValid_i,
   input  logic [NUM_LANES*PKT_W-1:0]                   inPkt_i,
   output logic                                         inReady_o,
   output logic [NUM_LANES-1:0]                         outValid_o,
   output logic [NUM_LANES*PKT_W-1:0]                   outPkt_o,
   input  logic [NUM_LANES-1:0]                         outReady_i,
   output logic                                         validBundle_o,
   output logic [NUM_LANES*($clog2(SKID_DEPTH)+1)-1:0]  occupancy_o
);

   localparam int PTR_W = $clog2(SKID_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SKID_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_QUIESCED = 2'd2
   } state_t;

   state_t               state_q;
   logic                 cfg_ack_q;
   logic                 in_ready;
   logic                 all_empty;
   logic [NUM_LANES-1:0] out_valid;
   logic [NUM_LANES-1:0] cnt_nz;
   logic [NUM_LANES-1:0] lane_room;

   // Issue is allowed only while running, not flushing, and every active
   // lane has a free slot. Registered counts only: a pop in this cycle does
   // not make room for a push in the same cycle.
   assign in_ready  = (state_q == ST_RUN) && !flush_i && (&lane_room);
   assign all_empty = ~|cnt_nz;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
         logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             push;
         logic             pop;
         logic [PKT_W-1:0] mem_q [SKID_DEPTH];

         assign push = in_ready && inValid_i[gi] && laneActive_i[gi];
         assign pop  = out_valid[gi] && outReady_i[gi];

         // Next-state pointers and count. A flush or an inactive lane empties the lane.
         always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (flush_i || !laneActive_i[gi]) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               cnt_d    = '0;
            end else begin
               if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
               if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               case ({push, pop})
                  2'b10:   cnt_d = cnt_q + CNT_W'(1);
                  2'b01:   cnt_d = cnt_q - CNT_W'(1);
                  default: cnt_d = cnt_q;
               endcase
            end
         end

         // Lane pointer and count registers.
         always_ff @(posedge clk) begin
            if (reset) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               cnt_q    <= cnt_d;
            end
         end

         // Payload storage. It is not reset because an empty lane masks its output to zero.
         always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= inPkt_i[gi*PKT_W +: PKT_W];
         end

         assign cnt_nz[gi]    = (cnt_q != '0);
         assign lane_room[gi] = !laneActive_i[gi] || (cnt_q < FULL_CNT);
         assign out_valid[gi] = laneActive_i[gi] && cnt_nz[gi];
         assign outPkt_o[gi*PKT_W +: PKT_W]    = cnt_nz[gi] ? mem_q[rd_ptr_q] : '0;
         assign occupancy_o[gi*CNT_W +: CNT_W] = cnt_q;
      end
   endgenerate

   // Quiesce FSM. The acknowledge is registered and follows the QUIESCED state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         cfg_ack_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (cfgReq_i) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!cfgReq_i) begin
                  state_q <= ST_RUN;
               end else if (all_empty) begin
                  state_q   <= ST_QUIESCED;
                  cfg_ack_q <= 1'b1;
               end
            end
            ST_QUIESCED: begin
               if (!cfgReq_i) begin
                  state_q   <= ST_RUN;
                  cfg_ack_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_RUN;
               cfg_ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign inReady_o     = in_ready;
   assign outValid_o    = out_valid;
   assign validBundle_o = |out_valid;
   assign cfgAck_o      = cfg_ack_q;

endmodule
